// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and default baud divisor.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;

    // Common UART FSM states; the transmitter uses the same codes where names coincide.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        CLEANUP    = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

    // 2-of-3 vote used for noise-tolerant bit decisions.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: raw serial input plus the byte/strobe/status outputs.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      i_RX_Serial;
    logic [UART_DATA_BITS-1:0] o_RX_Byte;
    logic                      o_RX_DV;
    logic                      o_RX_Frame_Err;
    logic                      o_RX_Busy;

    // master drives the line and consumes results; slave is the receiver itself
    modport master (
        output i_RX_Serial,
        input  o_RX_Byte,
        input  o_RX_DV,
        input  o_RX_Frame_Err,
        input  o_RX_Busy
    );

    modport slave (
        input  i_RX_Serial,
        output o_RX_Byte,
        output o_RX_DV,
        output o_RX_Frame_Err,
        output o_RX_Busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin, with a configurable reset level.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the pin through two stages
    always_comb begin
        sync_d = {sync_q[0], async_i};
    end

    // synchroniser flops, reset to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Mid-bit sampling, framing-error report and break handling.
// Optional UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3 vote around mid-bit,
// shifting every decision one clock later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      i_Clk,
    input  logic      i_Rst_L,
    uart_rx_if.slave  rx_if
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF   = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_DEC_C = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] START_S0_C  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] START_S1_C  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] BIT_S0_C    = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] BIT_S1_C    = CNT_W'(CLKS_PER_BIT - 2);
`else
    localparam logic [CNT_W-1:0] START_DEC_C = CNT_W'(HALF);
`endif

    logic                      rx_s;
    logic                      bit_val;
    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      dv_q, dv_d;
    logic                      fe_q, fe_d;
    logic                      busy_q, busy_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]                smp_q, smp_d;
`endif

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk     (i_Clk),
        .rst_n   (i_Rst_L),
        .async_i (rx_if.i_RX_Serial),
        .sync_o  (rx_s)
    );

    // bit decision: direct sample or vote over the two earlier samples plus the current one
    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        bit_val = maj3(smp_q[0], smp_q[1], rx_s);
`else
        bit_val = rx_s;
`endif
    end

    // next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        busy_d  = busy_q;
`ifdef UART_RX_MAJORITY_EN
        smp_d   = smp_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                busy_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
`ifdef UART_RX_MAJORITY_EN
                if (cnt_q == START_S0_C) smp_d[0] = rx_s;
                if (cnt_q == START_S1_C) smp_d[1] = rx_s;
`endif
                if (cnt_q == START_DEC_C) begin
                    cnt_d   = '0;
                    state_d = bit_val ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
`ifdef UART_RX_MAJORITY_EN
                if (cnt_q == BIT_S0_C) smp_d[0] = rx_s;
                if (cnt_q == BIT_S1_C) smp_d[1] = rx_s;
`endif
                if (cnt_q == LAST_C) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
`ifdef UART_RX_MAJORITY_EN
                if (cnt_q == BIT_S0_C) smp_d[0] = rx_s;
                if (cnt_q == BIT_S1_C) smp_d[1] = rx_s;
`endif
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLEANUP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            BREAK_WAIT: begin
                // a held-low line reports one framing error, then waits for idle
                if (rx_s) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            smp_q   <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            smp_q   <= smp_d;
`endif
        end
    end

    assign rx_if.o_RX_Byte      = byte_q;
    assign rx_if.o_RX_DV        = dv_q;
    assign rx_if.o_RX_Frame_Err = fe_q;
    assign rx_if.o_RX_Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, multi-cycle corner cases, random frames.
module tb_uart_rx;

    localparam int CPB  = 217;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    // edge (relative to the start-bit edge) at which DV / frame error is seen
    localparam int EV_LAT = 3 + HALF + 9 * CPB + OFS;
    // pin cycle that the single-sample receiver uses for data bit 2
    localparam int GLITCH_K = 1 + HALF + 3 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] b;
        logic       fe;
    } ev_t;

    ev_t  evq[$];
    int   overlap     = 0;
    int   busy_fall_t = -1;
    logic busy_prev   = 1'b0;

    // record every strobe with its edge number
    always @(posedge clk) begin
        #1;
        if (rx_if.o_RX_DV || rx_if.o_RX_Frame_Err)
            evq.push_back('{t: cyc, b: rx_if.o_RX_Byte, fe: rx_if.o_RX_Frame_Err});
        if (rx_if.o_RX_DV && rx_if.o_RX_Frame_Err) overlap++;
        if (busy_prev && !rx_if.o_RX_Busy) busy_fall_t = cyc;
        busy_prev = rx_if.o_RX_Busy;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_if.i_RX_Serial = v;
        end
    endtask

    // drive the first ncyc pin cycles of a frame; optional one-cycle high glitch at cycle gk
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gk,
                              input int ncyc, output int t0);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        t0 = cyc + 1;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            rx_if.i_RX_Serial = (k == gk) ? 1'b1 : fr[k / CPB];
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_event(input string name, input int t0, input logic [7:0] eb,
                               input logic efe);
        ev_t ev;
        int  w;
        w = 0;
        while (evq.size() == 0 && w < 3 * CPB) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (evq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: actual=no strobe required=strobe", name);
            return;
        end
        ev = evq.pop_front();
        chk({name, "_edge"}, ev.t - t0, EV_LAT);
        chk({name, "_byte"}, ev.b, eb);
        chk({name, "_fe"}, ev.fe, efe);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold_low;
        int         idle_hi;
        logic       exp_fe;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vt[6];
    int         t0;
    logic [7:0] model_byte;
    logic [7:0] rb;
    logic       rs;
    logic [7:0] glitch_exp;

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b1, 0,    20, 1'b0, 8'hA5};
        vt[1] = '{8'h00, 1'b1, 0,    0,  1'b0, 8'h00};
        vt[2] = '{8'hFF, 1'b1, 0,    30, 1'b0, 8'hFF};
        vt[3] = '{8'h3C, 1'b0, 5000, 30, 1'b1, 8'hFF};
        vt[4] = '{8'h3C, 1'b1, 0,    30, 1'b0, 8'h3C};
        vt[5] = '{8'h81, 1'b0, 0,    10, 1'b1, 8'h3C};

        rx_if.i_RX_Serial = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_byte", rx_if.o_RX_Byte, 0);
        chk("rst_dv", rx_if.o_RX_DV, 0);
        chk("rst_fe", rx_if.o_RX_Frame_Err, 0);
        chk("rst_busy", rx_if.o_RX_Busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 10);

        // directed table
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].data, vt[i].stop, -1, 10 * CPB, t0);
            check_event($sformatf("vec%0d", i), t0, vt[i].exp_byte, vt[i].exp_fe);
            if (!vt[i].exp_fe) chk($sformatf("vec%0d_busy_fall", i), busy_fall_t - t0, EV_LAT + 1);
            if (!vt[i].stop) begin
                drive(1'b0, vt[i].hold_low);
                if (vt[i].hold_low > 0) chk($sformatf("vec%0d_break_busy", i), rx_if.o_RX_Busy, 1);
            end
            drive(1'b1, vt[i].idle_hi);
            chk($sformatf("vec%0d_no_extra", i), evq.size(), 0);
            chk($sformatf("vec%0d_hold", i), rx_if.o_RX_Byte, vt[i].exp_byte);
        end
        model_byte = 8'h3C;

        // 50-cycle low glitch on idle line: rejected at start-bit check
        @(negedge clk);
        t0 = cyc + 1;
        rx_if.i_RX_Serial = 1'b0;
        drive(1'b0, 49);
        drive(1'b1, 1);
        wait_edge(t0 + 3 + HALF + OFS);
        chk("glitch_busy_hi", rx_if.o_RX_Busy, 1);
        wait_edge(t0 + 4 + HALF + OFS);
        chk("glitch_busy_lo", rx_if.o_RX_Busy, 0);
        drive(1'b1, 200);
        chk("glitch_no_strobe", evq.size(), 0);

        // reset during data bit 4
        send_frame(8'h5A, 1'b1, -1, 5 * CPB + CPB / 2, t0);
        chk("midrst_busy_before", rx_if.o_RX_Busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_byte", rx_if.o_RX_Byte, 0);
        chk("midrst_busy", rx_if.o_RX_Busy, 0);
        chk("midrst_dv", rx_if.o_RX_DV, 0);
        chk("midrst_fe", rx_if.o_RX_Frame_Err, 0);
        rx_if.i_RX_Serial = 1'b1;
        drive(1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 50);
        chk("midrst_no_strobe", evq.size(), 0);
        send_frame(8'h5A, 1'b1, -1, 10 * CPB, t0);
        check_event("after_rst", t0, 8'h5A, 1'b0);
        drive(1'b1, 20);
        model_byte = 8'h5A;

        // one-cycle high glitch at the centre of data bit 2 of 8'h00
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h04;
`endif
        send_frame(8'h00, 1'b1, GLITCH_K, 10 * CPB, t0);
        check_event("bit2_glitch", t0, glitch_exp, 1'b0);
        drive(1'b1, 20);
        model_byte = glitch_exp;

        // random frames against the frame-level model
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, -1, 10 * CPB, t0);
            if (rs) model_byte = rb;
            check_event($sformatf("rnd%0d", i), t0, model_byte, !rs);
            if (!rs) begin
                drive(1'b0, $urandom_range(0, 200));
                drive(1'b1, $urandom_range(4, 300));
            end else begin
                drive(1'b1, $urandom_range(0, 300));
            end
            chk($sformatf("rnd%0d_hold", i), rx_if.o_RX_Byte, model_byte);
        end

        drive(1'b1, 20);
        chk("no_stray", evq.size(), 0);
        chk("dv_fe_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver (8N1, LSB first) that pairs with the existing UART transmitter on the same `CLKS_PER_BIT` baud configuration. It synchronises the raw RX pin into the `i_Clk` domain, validates the start bit at mid-bit, shifts in 8 data bits and checks the stop bit. It delivers each byte as a one-cycle strobe to the core-side peripheral logic, or reports a framing error.

## Interface
- `CLKS_PER_BIT`, default 217: `i_Clk` cycles per bit. Must be ≥ 4. `HALF = (CLKS_PER_BIT-1)/2`, integer division.
- `i_Clk`  in  1  system clock.
- `i_Rst_L`  in  1  reset, asynchronous and active-low.
- `i_RX_Serial`  in  1  raw serial line. Asynchronous to `i_Clk`; idles high.
- `o_RX_Byte`  out  8  last correctly received byte. Holds its value until the next good byte.
- `o_RX_DV`  out  1  one-cycle pulse: `o_RX_Byte` has just been updated.
- `o_RX_Frame_Err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_RX_Busy`  out  1  high from start-bit detection until the return to IDLE.

## Operation
- Synchroniser: two flops, both reset to 1. Only the second stage (`rx_s`) feeds the FSM.
- Bit counter width is `$clog2(CLKS_PER_BIT)+1`. Bit index is 3 bits.
- **IDLE**: counter = 0, index = 0, `o_RX_Busy` = 0. If `rx_s` = 0, go to START and set busy.
- **START**: count up. When count == HALF, sample the line:
  - low: clear the counter and go to DATA.
  - high: glitch; go to IDLE with no output pulse.
- **DATA**: count up. When count == CLKS_PER_BIT-1:
  - sample into shift register bit[index] and clear the counter.
  - if index < 7, increment index; if index == 7, go to STOP.
- **STOP**: when count == CLKS_PER_BIT-1, sample the line:
  - 1: load `o_RX_Byte` from the shift register, pulse `o_RX_DV`, go to CLEANUP.
  - 0: pulse `o_RX_Frame_Err`, leave `o_RX_Byte` unchanged, go to BREAK_WAIT.
- **CLEANUP**: one cycle. Clear busy, go to IDLE.
- **BREAK_WAIT**: stay while `rx_s` = 0. When `rx_s` = 1, clear busy and go to IDLE. A line held low (break) therefore yields exactly one framing error, not repeated frames.
- `default`: go to IDLE.
- Reset (asserted at any time, including mid-frame):
  - all outputs 0, `o_RX_Byte` = 8'h00, shift register 0, state IDLE, synchroniser = 1.
  - a partially received frame is discarded with no pulse.
- `o_RX_DV` and `o_RX_Frame_Err` are never high in the same cycle.

## Timing
- Let edge 0 be the first `i_Clk` rising edge at which `i_RX_Serial` is low for the start bit.
- The FSM leaves IDLE at edge 2.
- Start bit is sampled at edge 3+HALF. Data bit n is sampled at edge 3+HALF+(n+1)·CLKS_PER_BIT.
- `o_RX_DV` or `o_RX_Frame_Err` is registered high at edge 3+HALF+9·CLKS_PER_BIT, i.e. edge 2064 for the default 217.
- Busy falls one edge later (CLEANUP).
- Back-to-back frames: the next falling edge may arrive ≥ HALF−4 cycles after the stop-bit sample; it is detected with no lost frame.
- Tolerated baud mismatch: ±4 % for the default parameter.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - each start, data and stop decision is a 2-of-3 majority of `rx_s` taken at count HALF−1, HALF and HALF+1.
  - in DATA and STOP the decision point is at count CLKS_PER_BIT-1 with samples taken at the corresponding offsets of the current bit.
  - all sample and decision edges above move +1 (DV at edge 2065 for the default).
  - a single-cycle glitch at mid-bit is rejected.
- `UART_RX_MAJORITY_EN` not defined: single sample at the instants in Timing. No extra flops.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encodings (IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT), 3 bits, shared with the transmitter's encodings where names coincide.
  - constants `UART_DATA_BITS = 8` and the default `CLKS_PER_BIT = 217`.
- One sub-module: `uart_rx_sync`, the two-flop synchroniser with reset value 1, reusable for other asynchronous pins.

## Test plan
- Send 8'hA5 at 217 clk/bit → `o_RX_DV` pulses once at edge 2064 (2065 with macro), `o_RX_Byte` = 8'hA5, `o_RX_Frame_Err` = 0.
- Send 8'h00 then 8'hFF back-to-back, zero idle between frames → two DV pulses carrying 8'h00 and 8'hFF.
- Low glitch of 50 cycles on an idle line → no DV, no error, busy returns low at ≈ edge 112.
- Frame 8'h3C with stop bit forced low, line then held low for 5000 cycles → one `o_RX_Frame_Err` pulse, `o_RX_Byte` keeps its previous value, no further pulses; next valid 8'h3C → DV with 8'h3C.
- Assert `i_Rst_L` low during data bit 4 of 8'h5A → all outputs 0 immediately; after release, a fresh 8'h5A is received correctly.
- With `UART_RX_MAJORITY_EN`: a 1-cycle high glitch at the centre of bit 2 of 8'h00 → byte received as 8'h00. Without the macro, the glitch placed on the sample edge → byte received as 8'h04.
